// File: rtl/l1_cache_pkg.sv
// L1 write-back cache shared types and geometry helpers.
// Geometry is derived from the top-level parameters via these functions.
package l1_cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL
  } state_t;

  function automatic int num_sets(
    input int cs,
    input int bs,
    input int nw
  );
    return cs / (bs * nw);
  endfunction

  function automatic int offset_width(input int bs);
    return $clog2(bs);
  endfunction

  function automatic int index_width(
    input int cs,
    input int bs,
    input int nw
  );
    return $clog2(num_sets(cs, bs, nw));
  endfunction

  function automatic int tag_width(
    input int aw,
    input int cs,
    input int bs,
    input int nw
  );
    return aw - index_width(cs, bs, nw) - offset_width(bs);
  endfunction

  function automatic int age_width(input int nw);
    return $clog2(nw);
  endfunction

endpackage

// File: rtl/l1_lru_tracker.sv
// True-LRU age tracker: one age per way per set, victim is the oldest way.
// Ages stay a permutation of 0..NUM_WAYS-1 within every set.
module l1_lru_tracker
  import l1_cache_pkg::*;
#(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 4,
  localparam int IW = $clog2(NUM_SETS),
  localparam int AW = age_width(NUM_WAYS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] set_idx,
  input  logic          access,
  input  logic [AW-1:0] way,
  output logic [AW-1:0] victim
);

  logic [AW-1:0] age_q [NUM_SETS][NUM_WAYS];
  logic [AW-1:0] acc_age;

  assign acc_age = age_q[set_idx][way];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          age_q[s][w] <= AW'(w);
    end else if (access) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (AW'(w) == way)
          age_q[set_idx][w] <= '0;
        else if (age_q[set_idx][w] < acc_age)
          age_q[set_idx][w] <= age_q[set_idx][w] + AW'(1);
      end
    end
  end

  always_comb begin
    victim = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (age_q[set_idx][w] == AW'(NUM_WAYS - 1))
        victim = AW'(w);
  end

endmodule

// File: rtl/l1_wb_cache.sv
// N-way write-back, write-allocate L1 data cache with true-LRU replacement.
// Define L1_WB_PERF_CNT_EN to add saturating hit/miss/writeback counters.
module l1_wb_cache
  import l1_cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CACHE_SIZE = 1024,
  parameter int BLOCK_SIZE = 16,
  parameter int NUM_WAYS   = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            cpu_addr,
  input  logic [DATA_WIDTH-1:0]            cpu_wdata,
  input  logic                             cpu_read,
  input  logic                             cpu_write,
  output logic [DATA_WIDTH-1:0]            cpu_rdata,
  output logic                             cpu_ready,
  output logic                             cpu_hit,
  output logic [ADDR_WIDTH-1:0]            l2_addr,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_wdata,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_rdata,
  output logic                             l2_read,
  output logic                             l2_write,
`ifdef L1_WB_PERF_CNT_EN
  output logic [31:0]                      perf_hits,
  output logic [31:0]                      perf_misses,
  output logic [31:0]                      perf_writebacks,
`endif
  input  logic                             l2_ready
);

  localparam int NUM_SETS = num_sets(CACHE_SIZE, BLOCK_SIZE, NUM_WAYS);
  localparam int IDX_W = index_width(CACHE_SIZE, BLOCK_SIZE, NUM_WAYS);
  localparam int OFF_W = offset_width(BLOCK_SIZE);
  localparam int TAG_W = tag_width(ADDR_WIDTH, CACHE_SIZE, BLOCK_SIZE, NUM_WAYS);
  localparam int AGE_W = age_width(NUM_WAYS);

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] req_addr_q, cur_addr;
  logic [DATA_WIDTH-1:0] req_wdata_q, fill_word;
  logic                  req_wr_q;
  logic [AGE_W-1:0]      victim_q, victim, lru_victim, hit_way, lru_way;
  logic [TAG_W-1:0]      cur_tag;
  logic [IDX_W-1:0]      cur_idx;
  logic [OFF_W-1:0]      cur_off;
  logic                  hit, accept, fill_done, lru_access, victim_dirty;

  logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
  logic [DATA_WIDTH-1:0] data_q  [NUM_SETS][NUM_WAYS][BLOCK_SIZE];
  logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]   dirty_q [NUM_SETS];

  // Outside IDLE the latched request drives every lookup.
  assign cur_addr = (state_q == IDLE) ? cpu_addr : req_addr_q;
  assign cur_tag  = cur_addr[ADDR_WIDTH-1 -: TAG_W];
  assign cur_idx  = cur_addr[OFF_W +: IDX_W];
  assign cur_off  = cur_addr[OFF_W-1:0];

  assign accept    = (state_q == IDLE) && (cpu_read || cpu_write);
  assign fill_done = (state_q == REFILL) && l2_ready;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    victim  = lru_victim;
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (!valid_q[cur_idx][w])
        victim = AGE_W'(w);
    for (int w = 0; w < NUM_WAYS; w++)
      if (valid_q[cur_idx][w] && tag_q[cur_idx][w] == cur_tag) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
  end

  assign victim_dirty = valid_q[cur_idx][victim] && dirty_q[cur_idx][victim];

  assign fill_word = req_wr_q ? req_wdata_q
                   : l2_rdata[int'(cur_off)*DATA_WIDTH +: DATA_WIDTH];

  assign lru_access = (accept && hit) || fill_done;
  assign lru_way    = fill_done ? victim_q : hit_way;

  l1_lru_tracker #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS)
  ) u_lru (
    .clk     (clk),
    .rst     (rst),
    .set_idx (cur_idx),
    .access  (lru_access),
    .way     (lru_way),
    .victim  (lru_victim)
  );

  always_comb begin
    state_d   = state_q;
    cpu_ready = 1'b0;
    l2_read   = 1'b0;
    l2_write  = 1'b0;
    l2_addr   = '0;
    l2_wdata  = '0;
    unique case (state_q)
      IDLE: begin
        cpu_ready = 1'b1;
        if (accept && !hit)
          state_d = victim_dirty ? WRITEBACK : REFILL;
      end
      WRITEBACK: begin
        l2_write = 1'b1;
        l2_addr  = {tag_q[cur_idx][victim_q], cur_idx, {OFF_W{1'b0}}};
        for (int k = 0; k < BLOCK_SIZE; k++)
          l2_wdata[k*DATA_WIDTH +: DATA_WIDTH] = data_q[cur_idx][victim_q][k];
        if (l2_ready)
          state_d = REFILL;
      end
      REFILL: begin
        l2_read = 1'b1;
        l2_addr = {cur_tag, cur_idx, {OFF_W{1'b0}}};
        if (l2_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wr_q    <= 1'b0;
      victim_q    <= '0;
      cpu_rdata   <= '0;
      cpu_hit     <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (accept) begin
        cpu_hit <= hit;
        if (hit) begin
          if (cpu_write)
            dirty_q[cur_idx][hit_way] <= 1'b1;
          else
            cpu_rdata <= data_q[cur_idx][hit_way][cur_off];
        end else begin
          req_addr_q  <= cpu_addr;
          req_wdata_q <= cpu_wdata;
          req_wr_q    <= cpu_write;
          victim_q    <= victim;
        end
      end
      if (fill_done) begin
        valid_q[cur_idx][victim_q] <= 1'b1;
        dirty_q[cur_idx][victim_q] <= req_wr_q;
        cpu_rdata                  <= fill_word;
        cpu_hit                    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && hit && cpu_write)
      data_q[cur_idx][hit_way][cur_off] <= cpu_wdata;
    if (fill_done) begin
      tag_q[cur_idx][victim_q] <= cur_tag;
      for (int k = 0; k < BLOCK_SIZE; k++)
        data_q[cur_idx][victim_q][k] <=
          (req_wr_q && OFF_W'(k) == cur_off) ? req_wdata_q
          : l2_rdata[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef L1_WB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hits       <= '0;
      perf_misses     <= '0;
      perf_writebacks <= '0;
    end else begin
      if (accept && hit && !(&perf_hits))
        perf_hits <= perf_hits + 32'd1;
      if (accept && !hit && !(&perf_misses))
        perf_misses <= perf_misses + 32'd1;
      if (state_q == WRITEBACK && l2_ready && !(&perf_writebacks))
        perf_writebacks <= perf_writebacks + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l1_wb_cache.sv
// Directed self-checking bench for l1_wb_cache (default geometry).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_l1_wb_cache;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic         cpu_read, cpu_write, cpu_ready, cpu_hit;
  logic [31:0]  l2_addr;
  logic [511:0] l2_wdata, l2_rdata;
  logic         l2_read, l2_write, l2_ready;
`ifdef L1_WB_PERF_CNT_EN
  logic [31:0]  perf_hits, perf_misses, perf_writebacks;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  l1_wb_cache dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_hit   (cpu_hit),
    .l2_addr   (l2_addr),
    .l2_wdata  (l2_wdata),
    .l2_rdata  (l2_rdata),
    .l2_read   (l2_read),
    .l2_write  (l2_write),
`ifdef L1_WB_PERF_CNT_EN
    .perf_hits       (perf_hits),
    .perf_misses     (perf_misses),
    .perf_writebacks (perf_writebacks),
`endif
    .l2_ready  (l2_ready)
  );

  task automatic chk(input string tg, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tg, obs, exp);
    end
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] d,
                     input logic rd, input logic wr);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_read  = rd;
    cpu_write = wr;
    @(negedge clk);
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  task automatic refill(input string tg, input logic [31:0] exp_addr,
                        input logic [31:0] base, input int dly);
    chk({tg, "_l2rd"}, 32'(l2_read), 32'd1);
    chk({tg, "_l2wr"}, 32'(l2_write), 32'd0);
    chk({tg, "_l2addr"}, l2_addr, exp_addr);
    chk({tg, "_busy"}, 32'(cpu_ready), 32'd0);
    repeat (dly) @(negedge clk);
    for (int k = 0; k < 16; k++)
      l2_rdata[k*32 +: 32] = base + 32'(k);
    l2_ready = 1'b1;
    @(negedge clk);
    l2_ready = 1'b0;
    chk({tg, "_done"}, 32'(cpu_ready), 32'd1);
    chk({tg, "_miss"}, 32'(cpu_hit), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    cpu_addr = '0;
    cpu_wdata = '0;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    l2_rdata = '0;
    l2_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(cpu_ready), 32'd1);
    chk("rst_hit", 32'(cpu_hit), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_l2rd", 32'(l2_read), 32'd0);
    chk("rst_l2wr", 32'(l2_write), 32'd0);
    chk("rst_l2addr", l2_addr, 32'd0);
    rst = 1'b0;

    // cold read miss, then hit
    req(32'h104, 32'h0, 1'b1, 1'b0);
    refill("t1", 32'h100, 32'hA000_0000, 3);
    chk("t1_rdata", cpu_rdata, 32'hA000_0004);
    req(32'h104, 32'h0, 1'b1, 1'b0);
    chk("t1_hit", 32'(cpu_hit), 32'd1);
    chk("t1_hit_rdata", cpu_rdata, 32'hA000_0004);
    chk("t1_hit_ready", 32'(cpu_ready), 32'd1);
    chk("t1_hit_l2rd", 32'(l2_read), 32'd0);

    // write hit then read back
    req(32'h104, 32'hDEAD_BEEF, 1'b0, 1'b1);
    chk("t2_whit", 32'(cpu_hit), 32'd1);
    chk("t2_w_rdata", cpu_rdata, 32'hA000_0004);
    chk("t2_w_l2wr", 32'(l2_write), 32'd0);
    req(32'h104, 32'h0, 1'b1, 1'b0);
    chk("t2_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("t2_hit", 32'(cpu_hit), 32'd1);
    chk("t2_l2rd", 32'(l2_read), 32'd0);
    chk("t2_l2wr", 32'(l2_write), 32'd0);

    // fill set 0, then evict the dirty line
    req(32'h200, 32'h0, 1'b1, 1'b0);
    refill("t3a", 32'h200, 32'hB000_0000, 0);
    req(32'h300, 32'h0, 1'b1, 1'b0);
    refill("t3b", 32'h300, 32'hC000_0000, 1);
    req(32'h400, 32'h0, 1'b1, 1'b0);
    refill("t3c", 32'h400, 32'hD000_0000, 0);
    chk("t3c_rdata", cpu_rdata, 32'hD000_0000);
    req(32'h500, 32'h0, 1'b1, 1'b0);
    chk("t3_wb_l2wr", 32'(l2_write), 32'd1);
    chk("t3_wb_l2rd", 32'(l2_read), 32'd0);
    chk("t3_wb_addr", l2_addr, 32'h100);
    chk("t3_wb_w4", l2_wdata[4*32 +: 32], 32'hDEAD_BEEF);
    chk("t3_wb_w0", l2_wdata[0 +: 32], 32'hA000_0000);
    repeat (2) @(negedge clk);
    chk("t3_wb_hold", 32'(l2_write), 32'd1);
    l2_ready = 1'b1;
    @(negedge clk);
    l2_ready = 1'b0;
    chk("t3_wb_drop", 32'(l2_write), 32'd0);
    refill("t3e", 32'h500, 32'hE000_0000, 1);
    chk("t3e_rdata", cpu_rdata, 32'hE000_0000);

    // clean fill, touch 0x100, miss evicts 0x200
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req(32'h100, 32'h0, 1'b1, 1'b0);
    refill("t4a", 32'h100, 32'h1000_0000, 0);
    req(32'h200, 32'h0, 1'b1, 1'b0);
    refill("t4b", 32'h200, 32'h2000_0000, 0);
    req(32'h300, 32'h0, 1'b1, 1'b0);
    refill("t4c", 32'h300, 32'h3000_0000, 0);
    req(32'h400, 32'h0, 1'b1, 1'b0);
    refill("t4d", 32'h400, 32'h4000_0000, 0);
    req(32'h100, 32'h0, 1'b1, 1'b0);
    chk("t4_rehit", 32'(cpu_hit), 32'd1);
    req(32'h500, 32'h0, 1'b1, 1'b0);
    refill("t4e", 32'h500, 32'h5000_0000, 0);
    req(32'h100, 32'h0, 1'b1, 1'b0);
    chk("t4_100_hit", 32'(cpu_hit), 32'd1);
    chk("t4_100_rdata", cpu_rdata, 32'h1000_0000);
    req(32'h300, 32'h0, 1'b1, 1'b0);
    chk("t4_300_hit", 32'(cpu_hit), 32'd1);
    req(32'h208, 32'h0, 1'b1, 1'b0);
    refill("t4f", 32'h200, 32'h6000_0000, 0);
    chk("t4f_rdata", cpu_rdata, 32'h6000_0008);

    // write miss merges data into the fill
    req(32'h713, 32'h0000_0077, 1'b0, 1'b1);
    refill("t4w", 32'h710, 32'h7000_0000, 0);
    chk("t4w_rdata", cpu_rdata, 32'h0000_0077);
    req(32'h711, 32'h0, 1'b1, 1'b0);
    chk("t4w_nb_hit", 32'(cpu_hit), 32'd1);
    chk("t4w_nb_rdata", cpu_rdata, 32'h7000_0001);
    req(32'h713, 32'h0, 1'b1, 1'b0);
    chk("t4w_rd_rdata", cpu_rdata, 32'h0000_0077);

    // reset during refill aborts the miss
    req(32'h600, 32'h0, 1'b1, 1'b0);
    chk("t5_l2rd", 32'(l2_read), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_abort_l2rd", 32'(l2_read), 32'd0);
    chk("t5_abort_ready", 32'(cpu_ready), 32'd1);
    chk("t5_abort_addr", l2_addr, 32'd0);
    req(32'h104, 32'h0, 1'b1, 1'b0);
    refill("t5", 32'h100, 32'hC000_0000, 2);
    chk("t5_rdata", cpu_rdata, 32'hC000_0004);

    // read+write together acts as a write
    req(32'h104, 32'h1234_5678, 1'b1, 1'b1);
    chk("t6_hit", 32'(cpu_hit), 32'd1);
    chk("t6_rdata_kept", cpu_rdata, 32'hC000_0004);
    req(32'h104, 32'h0, 1'b1, 1'b0);
    chk("t6_rdata", cpu_rdata, 32'h1234_5678);

    // stray l2_ready while idle is ignored
    l2_ready = 1'b1;
    @(negedge clk);
    l2_ready = 1'b0;
    chk("t7_ready", 32'(cpu_ready), 32'd1);
    chk("t7_l2rd", 32'(l2_read), 32'd0);
    req(32'h104, 32'h0, 1'b1, 1'b0);
    chk("t7_hit", 32'(cpu_hit), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
